// File: rtl/div_arbiter.sv
// Round-robin share of one divider: grant -> 1-cycle DIV_START -> wait DIV_VALID -> 1-cycle ACK; no new grant while DIV_BUSY.
// Define DIVARB_TIMEOUT_EN to abort a divide after TOUT_CYC silent WAIT cycles (DIV_SCLR pulse, ACK with RES_TOUT).
module div_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 10,
    parameter int TOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              SCLR,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    output logic [NREQ-1:0]   ACK,
    output logic [NREQ-1:0]   GNT,
    output logic [W-1:0]      RES_Q,
    output logic              RES_DVZ,
    output logic              RES_OVF,
    output logic              RES_TOUT,
    output logic              ARB_BUSY,
    output logic [W-1:0]      DIV_A,
    output logic [W-1:0]      DIV_B,
    output logic              DIV_START,
    output logic              DIV_SCLR,
    input  logic [W-1:0]      DIV_QOUT,
    input  logic              DIV_DVZ,
    input  logic              DIV_OVF,
    input  logic              DIV_BUSY,
    input  logic              DIV_VALID
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, owner, win_idx, cand;
    logic            win_vld, do_grant, do_fin;
    logic [W-1:0]    sel_a, sel_b, fin_q;
    logic            fin_dvz, fin_ovf;

`ifdef DIVARB_TIMEOUT_EN
    localparam int CW = $clog2(TOUT_CYC + 1);
    logic [CW-1:0]   tcnt;
    logic            tout_hit, do_tout;
    assign tout_hit = (tcnt == CW'(TOUT_CYC - 1));
`endif

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k >= NREQ) ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
            if (REQ[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IW'(k)) begin
                sel_a = REQ_A[k*W +: W];
                sel_b = REQ_B[k*W +: W];
            end
        end
    end

    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        do_fin   = 1'b0;
        fin_q    = DIV_QOUT;
        fin_dvz  = DIV_DVZ;
        fin_ovf  = DIV_OVF;
`ifdef DIVARB_TIMEOUT_EN
        do_tout  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (win_vld && !DIV_BUSY) begin
                    state_nx = ISSUE;
                    do_grant = 1'b1;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (DIV_VALID) begin
                    state_nx = RESP;
                    do_fin   = 1'b1;
                end
`ifdef DIVARB_TIMEOUT_EN
                else if (tout_hit) begin
                    state_nx = RESP;
                    do_fin   = 1'b1;
                    do_tout  = 1'b1;
                    fin_q    = '0;
                    fin_dvz  = 1'b0;
                    fin_ovf  = 1'b0;
                end
`endif
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            ptr       <= '0;
            owner     <= '0;
            GNT       <= '0;
            ACK       <= '0;
            RES_Q     <= '0;
            RES_DVZ   <= 1'b0;
            RES_OVF   <= 1'b0;
            DIV_A     <= '0;
            DIV_B     <= '0;
            DIV_START <= 1'b0;
            ARB_BUSY  <= 1'b0;
        end else begin
            DIV_START <= do_grant;
            ARB_BUSY  <= (state_nx != IDLE);
            ACK       <= '0;
            if (do_grant) begin
                owner <= win_idx;
                GNT   <= NREQ'(1) << win_idx;
                DIV_A <= sel_a;
                DIV_B <= sel_b;
            end
            if (do_fin) begin
                ACK     <= GNT;
                RES_Q   <= fin_q;
                RES_DVZ <= fin_dvz;
                RES_OVF <= fin_ovf;
            end
            if (state == RESP) begin
                GNT <= '0;
                ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

`ifdef DIVARB_TIMEOUT_EN
    // Counter is zeroed during ISSUE so every WAIT starts from a fresh budget.
    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            tcnt     <= '0;
            DIV_SCLR <= 1'b0;
            RES_TOUT <= 1'b0;
        end else begin
            DIV_SCLR <= do_tout;
            if (do_fin) RES_TOUT <= do_tout;
            if (state == ISSUE)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign DIV_SCLR = 1'b0;
    assign RES_TOUT = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider model plus round-robin reference, directed and random phases.
module tb_div_arbiter;
    logic        CLK = 1'b0;
    logic        SCLR = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [9:0]  opa [4];
    logic [9:0]  opb [4];
    logic [39:0] req_a, req_b;
    logic [3:0]  ACK, GNT;
    logic [9:0]  RES_Q, DIV_A, DIV_B, DIV_QOUT;
    logic        RES_DVZ, RES_OVF, RES_TOUT, ARB_BUSY, DIV_START, DIV_SCLR;
    logic        DIV_DVZ, DIV_OVF, DIV_BUSY, DIV_VALID;
    logic [43:0] all_outs;

    int ncmp = 0, nerr = 0;
    int p_model = 0, grants = 0, lat = 4, cyc = 0;
    int starts = 0, overlaps = 0, vld_edge = 0, sclr_seen = 0;
    bit hang = 0, spur = 0, busy_force = 0, expect_quick = 0;

    logic       m_busy = 0, m_vld = 0, m_dvz = 0, m_ovf = 0;
    logic [9:0] m_a = '0, m_b = '0, m_q = '0;
    int         m_cnt = 0;

    assign req_a = {opa[3], opa[2], opa[1], opa[0]};
    assign req_b = {opb[3], opb[2], opb[1], opb[0]};
    assign all_outs = {ACK, GNT, RES_Q, RES_DVZ, RES_OVF, RES_TOUT, ARB_BUSY,
                       DIV_A, DIV_B, DIV_START, DIV_SCLR};
    assign DIV_QOUT  = m_q;
    assign DIV_DVZ   = m_dvz;
    assign DIV_OVF   = m_ovf;
    assign DIV_BUSY  = m_busy | busy_force;
    assign DIV_VALID = m_vld | spur;

    div_arbiter #(.NREQ(4), .W(10), .TOUT_CYC(64)) dut (
        .CLK(CLK), .SCLR(SCLR), .REQ(req), .REQ_A(req_a), .REQ_B(req_b),
        .ACK(ACK), .GNT(GNT), .RES_Q(RES_Q), .RES_DVZ(RES_DVZ), .RES_OVF(RES_OVF),
        .RES_TOUT(RES_TOUT), .ARB_BUSY(ARB_BUSY), .DIV_A(DIV_A), .DIV_B(DIV_B),
        .DIV_START(DIV_START), .DIV_SCLR(DIV_SCLR), .DIV_QOUT(DIV_QOUT),
        .DIV_DVZ(DIV_DVZ), .DIV_OVF(DIV_OVF), .DIV_BUSY(DIV_BUSY), .DIV_VALID(DIV_VALID)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (DIV_SCLR === 1'b1 || RES_TOUT === 1'b1) sclr_seen++;

    // Q5.5 fixed-point divide: {quotient, dvz, ovf}
    function automatic logic [11:0] ref_div(input logic [9:0] a, input logic [9:0] b);
        int t;
        if (b == 10'd0) return {10'h3FF, 1'b1, 1'b0};
        t = (int'(a) * 32) / int'(b);
        if (t > 1023) return {10'h3FF, 1'b0, 1'b1};
        return {t[9:0], 1'b0, 1'b0};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (((r >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    // Divider model: samples DIV_START, answers after lat cycles unless hung.
    always @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            m_busy <= 1'b0;
            m_vld  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_vld <= 1'b0;
            if (DIV_SCLR) begin
                m_busy <= 1'b0;
            end else if (DIV_START) begin
                starts <= starts + 1;
                if (m_busy) overlaps <= overlaps + 1;
                m_busy <= 1'b1;
                m_cnt  <= lat;
                m_a    <= DIV_A;
                m_b    <= DIV_B;
            end else if (m_busy && !hang) begin
                if (m_cnt <= 1) begin
                    m_vld <= 1'b1;
                    m_busy <= 1'b0;
                    {m_q, m_dvz, m_ovf} <= ref_div(m_a, m_b);
                    vld_edge <= cyc + 1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_ops(input int i);
        opa[i] = 10'($urandom_range(0, 1023));
        opb[i] = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 300));
    endtask

    // One full transaction from the idle side: grant, start, result, ack.
    task automatic serve(input bit keep, input bit scribble, output int who);
        int n;
        int w;
        logic [11:0] r;
        n = 0;
        while (GNT === 4'b0 && n < 300) begin @(negedge CLK); n++; end
        chk("grant_wait_bound", 64'(n < 300), 1);
        if (expect_quick) chk("back_to_back_gap", n, 1);
        w = pick(req, p_model);
        chk("pick_valid", 64'(w >= 0), 1);
        if (w < 0) w = 0;
        who = w;
        grants++;
        chk("gnt_owner", GNT, 4'b0001 << w);
        chk("div_operands", {DIV_A, DIV_B}, {opa[w], opb[w]});
        chk("start_with_grant", {DIV_START, ARB_BUSY}, 2'b11);
        r = ref_div(opa[w], opb[w]);
        @(negedge CLK);
        chk("start_one_cycle", DIV_START, 0);
        if (scribble) begin
            new_ops(w);
            req[w] = 1'b0;
        end
        n = 0;
        while (ACK === 4'b0 && n < 300) begin @(negedge CLK); n++; end
        chk("ack_wait_bound", 64'(n < 300), 1);
        chk("ack_strobe", ACK, 4'b0001 << w);
        chk("gnt_held_at_ack", GNT, 4'b0001 << w);
        chk("ack_after_valid", cyc, vld_edge + 1);
        chk("result", {RES_Q, RES_DVZ, RES_OVF, RES_TOUT}, {r, 1'b0});
        p_model = (w + 1) % 4;
        if (keep) begin
            req[w] = 1'b1;
            new_ops(w);
        end else begin
            req[w] = 1'b0;
        end
        @(negedge CLK);
        chk("ack_gnt_cleared", {ACK, GNT, ARB_BUSY}, 9'b0);
        expect_quick = (req != 4'b0) && !busy_force;
    endtask

`ifdef DIVARB_TIMEOUT_EN
    task automatic tout_case();
        int n;
        int w;
        hang = 1'b1;
        req = 4'b0001;
        n = 0;
        while (GNT === 4'b0 && n < 50) begin @(negedge CLK); n++; end
        w = pick(req, p_model);
        grants++;
        chk("tout_grant", GNT, 4'b0001 << w);
        chk("tout_start", DIV_START, 1);
        n = 0;
        while (DIV_SCLR !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        chk("tout_sclr_delay", n, 65);
        chk("tout_ack", ACK, 4'b0001 << w);
        chk("tout_result", {RES_Q, RES_DVZ, RES_OVF, RES_TOUT}, 13'h001);
        req[w] = 1'b0;
        hang = 1'b0;
        p_model = (w + 1) % 4;
        @(negedge CLK);
        chk("tout_sclr_pulse", {DIV_SCLR, ACK}, 5'b0);
        expect_quick = 1'b0;
        req[1] = 1'b1;
        new_ops(1);
        serve(0, 0, w);
        chk("after_tout_who", w, 1);
    endtask
`endif

    initial begin
        int who;
        int n;
        for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = 10'd1; end
        #1 SCLR = 1'b1;
        #1 chk("reset_outputs_async", all_outs, 0);
        repeat (2) @(negedge CLK);
        chk("reset_outputs_held", all_outs, 0);
        SCLR = 1'b0;

        // single request, fixed operands
        opa[0] = 10'b0010100000;
        opb[0] = 10'b0000100000;
        lat = 12;
        req = 4'b0001;
        serve(0, 0, who);
        chk("single_who", who, 0);
        chk("single_q", {RES_Q, RES_DVZ, RES_OVF}, {10'h0A0, 2'b00});
        chk("single_start_count", starts, 1);

        // all four after reset: 0,1,2,3
        SCLR = 1'b1;
        @(negedge CLK);
        SCLR = 1'b0;
        p_model = 0;
        expect_quick = 1'b0;
        for (int i = 0; i < 4; i++) new_ops(i);
        lat = 5;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve(0, 0, who);
            chk("rr_all_four", who, k);
        end

        // 0 and 2 held: alternate
        for (int i = 0; i < 4; i++) new_ops(i);
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            lat = 2 + k;
            serve(k < 4, 0, who);
            chk("alternate_0_2", who, (k % 2 == 0) ? 0 : 2);
        end

        // divide by zero, then a clean divide
        opa[1] = 10'd100; opb[1] = 10'd0;
        req = 4'b0010;
        serve(0, 0, who);
        chk("dvz_set", RES_DVZ, 1);
        opa[1] = 10'd21; opb[1] = 10'd7;
        req = 4'b0010;
        serve(0, 0, who);
        chk("dvz_clear", {RES_Q, RES_DVZ}, {10'd96, 1'b0});

        // divider busy holds off the grant
        busy_force = 1'b1;
        new_ops(0);
        req = 4'b0001;
        repeat (6) @(negedge CLK);
        chk("busy_blocks_grant", {GNT, ARB_BUSY}, 5'b0);
        busy_force = 1'b0;
        serve(0, 0, who);
        chk("busy_release_who", who, 0);

        // stray DIV_VALID while idle
        spur = 1'b1;
        @(negedge CLK);
        spur = 1'b0;
        @(negedge CLK);
        chk("stray_valid_ignored", {ACK, GNT, ARB_BUSY}, 9'b0);

        // reset in WAIT: no ack, pointer back to 0
        new_ops(1);
        req = 4'b0010;
        serve(0, 0, who);
        chk("setup_ptr", who, 1);
        hang = 1'b1;
        new_ops(2);
        req = 4'b0100;
        n = 0;
        while (GNT === 4'b0 && n < 50) begin @(negedge CLK); n++; end
        grants++;
        chk("midwait_grant", GNT, 4'b0100);
        repeat (4) @(negedge CLK);
        chk("midwait_state", {ACK, ARB_BUSY}, 5'b00001);
        #2 SCLR = 1'b1;
        #1 chk("midwait_reset_outs", all_outs, 0);
        req = 4'b0;
        @(negedge CLK);
        chk("midwait_no_ack", ACK, 0);
        SCLR = 1'b0;
        hang = 1'b0;
        p_model = 0;
        expect_quick = 1'b0;
        new_ops(1);
        new_ops(3);
        req = 4'b1010;
        serve(0, 0, who);
        chk("post_reset_lowest", who, 1);
        serve(0, 0, who);
        chk("post_reset_next", who, 3);

        // random phase
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_ops(i);
                    req[i] = 1'b1;
                end
            end
            if (req == 4'b0) begin
                n = $urandom_range(0, 3);
                new_ops(n);
                req[n] = 1'b1;
            end
            lat = $urandom_range(1, 14);
            serve($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, who);
        end
        for (int d = 0; d < 4 && req != 4'b0; d++) serve(0, 0, who);

`ifdef DIVARB_TIMEOUT_EN
        tout_case();
`else
        chk("no_sclr_no_tout", sclr_seen, 0);
`endif
        chk("starts_equal_grants", starts, grants);
        chk("no_start_overlap", overlaps, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one fixed-point divider (10-bit operand/quotient, START/BUSY/VALID handshake, DVZ/OVF flags) between NREQ requesters. It latches the winning requester's operands and issues a single-cycle start pulse to the divider. It then waits for the result and returns quotient and flags to that requester with a one-cycle acknowledge. It sits between the requesting datapath units and the single divider instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 10: operand/quotient width.
- TOUT_CYC, 64: watchdog limit in WAIT cycles. Used only with DIVARB_TIMEOUT_EN.
- CLK  in  1  clock, rising edge.
- SCLR  in  1  reset, asynchronous, active-high.
- REQ  in  NREQ  request per requester. Held high until its ACK.
- REQ_A  in  NREQ*W  dividends, requester i at bits [i*W +: W].
- REQ_B  in  NREQ*W  divisors, same packing.
- ACK  out  NREQ  one-hot, one-cycle result strobe.
- GNT  out  NREQ  one-hot owner of the divider, from grant until ACK inclusive.
- RES_Q  out  W  quotient, valid while ACK is high.
- RES_DVZ, RES_OVF  out  1  divider flags, valid while ACK is high.
- RES_TOUT  out  1  watchdog abort flag, valid while ACK is high.
- ARB_BUSY  out  1  high whenever state is not IDLE.
- DIV_A, DIV_B  out  W  divider operands. Registered and stable from ISSUE through RESP.
- DIV_START  out  1  divider start, a one-cycle pulse.
- DIV_SCLR  out  1  divider clear, a one-cycle pulse.
- DIV_QOUT  in  W  divider quotient.
- DIV_DVZ, DIV_OVF, DIV_BUSY, DIV_VALID  in  1  divider status.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE
  - If any REQ is high and DIV_BUSY is 0: pick the winner i by searching from pointer P upward, mod NREQ.
  - Latch REQ_A[i] and REQ_B[i] into DIV_A and DIV_B, set GNT[i], go to ISSUE.
  - If DIV_BUSY is 1: stay in IDLE.
- ISSUE: DIV_START = 1 for this cycle only, then go to WAIT.
- WAIT
  - On the first edge with DIV_VALID = 1: capture DIV_QOUT, DIV_DVZ and DIV_OVF into the RES_* registers, go to RESP.
- RESP
  - ACK[i] = 1 for one cycle.
  - Set P = (i+1) mod NREQ, clear GNT, go to IDLE.
- Operands are latched at grant. If REQ[i] drops or REQ_A/REQ_B change after the grant, the operation still completes and ACK[i] still pulses.
- DIV_VALID seen in IDLE, ISSUE or RESP is ignored.
- RES_* hold their last values between ACKs. RES_TOUT is 0 for normal completions.

## Timing
- Reset
  - Async: state = IDLE, P = 0.
  - ACK, GNT, RES_*, DIV_A, DIV_B, DIV_START, DIV_SCLR and ARB_BUSY all 0.
- Reset mid-operation: abort immediately, no ACK. System reset clears the divider separately.
- Latency, REQ sampled at edge 0:
  - GNT and DIV_A/DIV_B valid after edge 1.
  - DIV_START high between edges 1 and 2.
  - DIV_VALID sampled at edge k gives ACK high between edges k and k+1.
- Back-to-back: the earliest next DIV_START is 2 cycles after ACK (IDLE, then ISSUE).
- A requester that raises REQ in the same cycle as its own ACK is treated as a new request.

## Configuration
- DIVARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. When TOUT_CYC cycles pass with no DIV_VALID, DIV_SCLR pulses one cycle and the state goes to RESP.
  - That ACK carries RES_TOUT = 1 and RES_Q, RES_DVZ, RES_OVF = 0.
  - The counter clears on entry to WAIT.
- DIVARB_TIMEOUT_EN undefined:
  - WAIT waits indefinitely. RES_TOUT and DIV_SCLR are tied to 0 and no counter exists.

## Test plan
- Single request: REQ[0] with A=10'b0010100000, B=10'b0000100000; model returns QOUT=10'h0A0 after 12 cycles.
  - Expect one DIV_START with those operands, GNT=4'b0001, ACK=4'b0001 for one cycle, RES_Q=10'h0A0, flags 0.
- All four REQ high after reset, held until ACK.
  - Expect ACK order 0,1,2,3, each exactly once, and no overlapping DIV_START.
- REQ[0] and REQ[2] held high continuously.
  - Expect grants alternating 0,2,0,2, with P wrapping 3 to 0 correctly.
- B=0; model returns DVZ=1.
  - Expect RES_DVZ=1 on ACK. Next request returns RES_DVZ=0.
- With DIVARB_TIMEOUT_EN and TOUT_CYC=64; model never asserts VALID.
  - Expect DIV_SCLR pulse 64 cycles after WAIT entry, then ACK with RES_TOUT=1 and RES_Q=0.
  - A following request completes normally.
- SCLR asserted mid-WAIT.
  - Expect all outputs 0 immediately, no ACK, and P=0 so the next grant goes to the lowest active REQ.
